// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers (MULT/MULTU/DIV/DIVU, MFHI/MFLO/MTHI/MTLO).
// Build option: define MULDIV_DIV_EN to compile in the restoring divider; otherwise DIV/DIVU are not unit ops.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  alu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result
);

  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
`ifdef MULDIV_DIV_EN
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] mag_a_q, mag_a_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
`ifdef MULDIV_DIV_EN
  logic        div_q, div_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
`endif

  logic        is_mfhi, is_mflo, is_mthi, is_mtlo, is_mul, is_div, unit_op;
  logic        op_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;
  logic        neg_res;

  always_comb begin
    is_mfhi   = (alu_op == OP_MFHI);
    is_mflo   = (alu_op == OP_MFLO);
    is_mthi   = (alu_op == OP_MTHI);
    is_mtlo   = (alu_op == OP_MTLO);
    is_mul    = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
`ifdef MULDIV_DIV_EN
    is_div    = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
`else
    is_div    = 1'b0;
`endif
    unit_op   = is_mfhi | is_mflo | is_mthi | is_mtlo | is_mul | is_div;
    // Funct codes 0x18/0x1A are the signed variants: bit 0 clear.
    op_signed = ~alu_op[0];
    abs_a     = (op_signed && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
    abs_b     = (op_signed && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mag_a_d  = mag_a_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    neg_res  = sign_a_q ^ sign_b_q;
    // Multiplier sits in acc[31:0]; partial product accumulates in the upper half and shifts down.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
    prod_fix = neg_res ? (~acc_q + 64'd1) : acc_q;
`ifdef MULDIV_DIV_EN
    div_d    = div_q;
    mag_b_d  = mag_b_q;
    rem_sh   = {acc_q[63:32], acc_q[31]};
    rem_diff = rem_sh - {1'b0, mag_b_q};
    quo_fix  = neg_res ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = sign_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul || is_div) begin
            sign_a_d = op_signed & rs_data[31];
            sign_b_d = op_signed & rt_data[31];
            mag_a_d  = abs_a;
            acc_d    = {32'd0, abs_b};
`ifdef MULDIV_DIV_EN
            div_d    = is_div;
            mag_b_d  = abs_b;
            if (is_div) acc_d = {32'd0, abs_a};
`endif
            cnt_d    = '0;
            state_d  = RUN;
          end else if (is_mthi) begin
            hi_d = rs_data;
          end else if (is_mtlo) begin
            lo_d = rs_data;
          end
        end
      end
      RUN: begin
        acc_d = {mul_sum, acc_q[31:1]};
`ifdef MULDIV_DIV_EN
        // Restoring step: remainder in acc[63:32], dividend shifts out / quotient shifts in at acc[31:0].
        if (div_q) begin
          if (!rem_diff[32]) acc_d = {rem_diff[31:0], acc_q[30:0], 1'b1};
          else               acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
        end
`endif
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        hi_d = prod_fix[63:32];
        lo_d = prod_fix[31:0];
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          if (mag_b_q == 32'd0) begin
            lo_d = '1;
            hi_d = sign_a_q ? (~mag_a_q + 32'd1) : mag_a_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_a_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q    <= 1'b0;
      mag_b_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mag_a_q  <= mag_a_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MULDIV_DIV_EN
      div_q    <= div_d;
      mag_b_q  <= mag_b_d;
`endif
    end
  end

  always_comb begin
    busy   = (state_q != IDLE);
    stall  = start & unit_op & busy;
    done   = done_q;
    hi     = hi_q;
    lo     = lo_q;
    result = '0;
    if (is_mfhi)      result = hi_q;
    else if (is_mflo) result = lo_q;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected HI/LO queued at issue, compared when done pulses.
module tb_ex_muldiv;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  alu_op;
  logic [31:0] rs_data, rt_data;
  logic        busy, stall, done;
  logic [31:0] hi, lo, result;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [63:0] sb_q[$];

  ex_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("sb_hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("sb_lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
    end
  end

  function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] qa, qb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    qa = a;
    qb = b;
    case (op)
      MULT:  return sa * sb;
      MULTU: return {32'd0, a} * {32'd0, b};
      DIV: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        return {32'(qa % qb), 32'(qa / qb)};
      end
      DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    alu_op  = op;
    rs_data = a;
    rt_data = b;
  endtask

  task automatic idle_in;
    start  = 1'b0;
    alu_op = 6'h00;
  endtask

  // Issues a mult/div and checks busy window, 34-edge latency to done, and a single done pulse.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int unsigned n;
    logic drop;
    sb_q.push_back(exp);
    drive(op, a, b);
    tick();
    idle_in();
    n = 1;
    drop = 1'b0;
    check({tag, "_busy_issue"}, {63'd0, busy}, 64'd1);
    while (!done && n < 60) begin
      tick();
      n++;
      if (!done && !busy) drop = 1'b1;
    end
    check({tag, "_latency"}, 64'(n), 64'd34);
    check({tag, "_busy_hold"}, {63'd0, drop}, 64'd0);
    check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
    tick();
    check({tag, "_done_once"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] hi_s, lo_s, ra, rb;
    logic [5:0]  rop;
    int unsigned n;

    rst = 1'b1;
    idle_in();
    rs_data = '0;
    rt_data = '0;
    tick();
    tick();
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    tick();

    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("mult_neg", MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);

`ifdef MULDIV_DIV_EN
    run_op("div_neg", DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu_zero", DIVU, 32'd100, 32'd0, 64'h00000064_FFFFFFFF);
    run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_op("div_zero_neg", DIV, 32'hFFFFFF00, 32'd0, 64'hFFFFFF00_FFFFFFFF);
`else
    hi_s = hi;
    lo_s = lo;
    drive(DIV, 32'hFFFFFFF9, 32'd2);
    tick();
    idle_in();
    check("nodiv_busy", {63'd0, busy}, 64'd0);
    tick();
    check("nodiv_hi", {32'd0, hi}, {32'd0, hi_s});
    check("nodiv_lo", {32'd0, lo}, {32'd0, lo_s});
`endif

    // MTHI / MTLO back-to-back, then reads.
    drive(MTHI, 32'h12345678, 32'd0);
    #1 check("mthi_stall", {63'd0, stall}, 64'd0);
    tick();
    check("mthi_hi", {32'd0, hi}, 64'h12345678);
    drive(MTLO, 32'hCAFEF00D, 32'd0);
    #1 check("mtlo_stall", {63'd0, stall}, 64'd0);
    tick();
    check("mtlo_lo", {32'd0, lo}, 64'hCAFEF00D);
    check("mtlo_hi_kept", {32'd0, hi}, 64'h12345678);
    drive(MFHI, 32'd0, 32'd0);
    #1 check("mfhi_result", {32'd0, result}, 64'h12345678);
    check("mfhi_stall", {63'd0, stall}, 64'd0);
    tick();
    drive(MFLO, 32'd0, 32'd0);
    #1 check("mflo_result", {32'd0, result}, 64'hCAFEF00D);
    check("mflo_stall", {63'd0, stall}, 64'd0);
    tick();
    drive(6'h20, 32'd0, 32'd0);
    #1 check("nonunit_result", {32'd0, result}, 64'd0);
    tick();
    idle_in();

    // Dependent MFLO arrives while a MULT is in flight.
    sb_q.push_back(64'hFFFFFFFF_FFFFFFF2);
    drive(MULT, 32'd7, 32'hFFFFFFFE);
    tick();
    idle_in();
    repeat (4) tick();
    drive(6'h20, 32'd0, 32'd0);
    #1 check("nonunit_busy_stall", {63'd0, stall}, 64'd0);
`ifndef MULDIV_DIV_EN
    drive(DIVU, 32'd9, 32'd3);
    #1 check("nodiv_busy_stall", {63'd0, stall}, 64'd0);
`endif
    drive(MFLO, 32'd0, 32'd0);
    n = 0;
    #1;
    while (!done && n < 60) begin
      check("dep_stall", {63'd0, stall}, 64'd1);
      tick();
      #1;
      n++;
    end
    check("dep_reached_done", {63'd0, done}, 64'd1);
    check("dep_done_stall", {63'd0, stall}, 64'd0);
    check("dep_done_result", {32'd0, result}, 64'hFFFFFFF2);
    tick();
    idle_in();
    tick();

    for (int i = 0; i < 6; i++) begin
      ra = $urandom();
      rb = $urandom();
`ifdef MULDIV_DIV_EN
      case (i % 4)
        0: rop = MULT;
        1: rop = MULTU;
        2: rop = DIV;
        default: rop = DIVU;
      endcase
      if (i == 3) rb = rb >> 20;
`else
      rop = (i % 2 == 0) ? MULT : MULTU;
`endif
      run_op("rand", rop, ra, rb, model(rop, ra, rb));
    end

    // Reset in the middle of an operation.
    check("pre_rst_nonzero", {63'd0, (hi != 32'd0) || (lo != 32'd0)}, 64'd1);
`ifdef MULDIV_DIV_EN
    drive(DIVU, 32'd1000, 32'd7);
`else
    drive(MULTU, 32'd1000, 32'd7);
`endif
    tick();
    idle_in();
    repeat (9) tick();
    check("midop_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    repeat (30) tick();
    check("midrst_still_idle", {63'd0, busy}, 64'd0);
    run_op("post_rst_multu", MULTU, 32'h00010000, 32'h00010000, 64'h00000001_00000000);

    repeat (3) tick();
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
